// File: rtl/clk_divider_prog_if.sv
// rtl/clk_divider_prog_if.sv - control/status bundle for the programmable clock divider
interface clk_divider_prog_if #(
  parameter int WIDTH = 8
);
  logic             i_enable;
  logic [WIDTH-1:0] i_div;
  logic             i_div_load;
  logic [WIDTH-1:0] o_count;
  logic             o_count_end;
  logic             o_div_clk;
  logic [WIDTH-1:0] o_div_cur;
  logic             o_div_pend;
  logic             o_div_upd;
  logic             o_div_err;

  modport master (
    output i_enable, i_div, i_div_load,
    input  o_count, o_count_end, o_div_clk, o_div_cur, o_div_pend, o_div_upd, o_div_err
  );

  modport slave (
    input  i_enable, i_div, i_div_load,
    output o_count, o_count_end, o_div_clk, o_div_cur, o_div_pend, o_div_upd, o_div_err
  );
endinterface

// File: rtl/clk_divider_prog.sv
// rtl/clk_divider_prog.sv - runtime-programmable 50%-duty integer clock divider
module clk_divider_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input logic               clk,
  input logic               resetn,
  clk_divider_prog_if.slave ctl
);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_DIV   = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_COUNT = WIDTH'(DEFAULT_DIV - 1);

  logic [WIDTH-1:0] div_cur;
  logic [WIDTH-1:0] div_pend;
  logic [WIDTH-1:0] count;
  logic             pend;
  logic             pos_q;
  logic             neg_q;
  logic             upd_q;
  logic             err_q;

  logic             load_ok;
  logic             load_bad;
  logic             wrap;
  logic             boundary;
  logic [WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH:0]   hi_nxt;
  logic             pos_nxt;

  // Divisor selection happens before the counter decode so a boundary edge
  // already counts and decodes against the newly applied N.
  always_comb begin
    load_ok  = ctl.i_div_load && (ctl.i_div >= TWO);
    load_bad = ctl.i_div_load && (ctl.i_div < TWO);
    wrap     = ctl.i_enable && (count == div_cur - ONE);
    boundary = !ctl.i_enable || wrap;

    div_nxt = div_cur;
    if (boundary) begin
      if (load_ok) begin
        div_nxt = ctl.i_div;
      end else if (pend) begin
        div_nxt = div_pend;
      end
    end

    hi_nxt = ({1'b0, div_nxt} + (WIDTH+1)'(1)) >> 1;

    if (!ctl.i_enable) begin
      count_nxt = div_nxt - ONE;
    end else if (wrap) begin
      count_nxt = '0;
    end else begin
      count_nxt = count + ONE;
    end

    pos_nxt = ctl.i_enable && ({1'b0, count_nxt} < hi_nxt);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cur  <= DEF_DIV;
      div_pend <= DEF_DIV;
      count    <= DEF_COUNT;
      pend     <= 1'b0;
      pos_q    <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      div_cur <= div_nxt;
      count   <= count_nxt;
      pos_q   <= pos_nxt;
      upd_q   <= boundary && (load_ok || pend);
      err_q   <= load_bad;
      if (boundary) begin
        pend <= 1'b0;
      end else if (load_ok) begin
        pend     <= 1'b1;
        div_pend <= ctl.i_div;
      end
    end
  end

  // Half-cycle delayed copy of the high phase; ANDed in for odd N to trim
  // half a clk off the rising edge.
  always_ff @(negedge clk) begin
    if (!resetn) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  assign ctl.o_count     = count;
  assign ctl.o_count_end = ctl.i_enable && (count == div_cur - ONE);
  assign ctl.o_div_clk   = div_cur[0] ? (pos_q & neg_q) : pos_q;
  assign ctl.o_div_cur   = div_cur;
  assign ctl.o_div_pend  = pend;
  assign ctl.o_div_upd   = upd_q;
  assign ctl.o_div_err   = err_q;
endmodule

// File: tb/tb_clk_divider_prog.sv
// tb/tb_clk_divider_prog.sv - self-checking bench for clk_divider_prog
module tb_clk_divider_prog;
  localparam int WIDTH = 8;
  localparam int DEF   = 5;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  clk_divider_prog_if #(.WIDTH(WIDTH)) ctl ();

  clk_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ctl    (ctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: divisor in effect, phase within the period, pending load
  int m_n;
  int m_count;
  int m_pend_val;
  bit m_pend;
  bit m_active;
  bit m_upd;
  bit m_err;
  bit m_ok;
  bit m_bnd;

  // Waveform measurements in half-clk units
  bit prev_s;
  int since_rise;
  int hi_run;
  int last_high;
  int last_period;
  int upd_seen;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!resetn) begin
      m_n = DEF; m_count = DEF - 1; m_pend = 0; m_pend_val = 0;
      m_active = 0; m_upd = 0; m_err = 0;
    end else begin
      m_ok  = ctl.i_div_load && (int'(ctl.i_div) >= 2);
      m_err = ctl.i_div_load && (int'(ctl.i_div) < 2);
      m_bnd = !ctl.i_enable || (m_count == m_n - 1);
      m_upd = 0;
      if (m_bnd) begin
        if (m_ok) begin m_n = int'(ctl.i_div); m_upd = 1; end
        else if (m_pend) begin m_n = m_pend_val; m_upd = 1; end
        m_pend = 0;
      end else if (m_ok) begin
        m_pend = 1; m_pend_val = int'(ctl.i_div);
      end
      if (ctl.i_enable) begin
        m_count  = m_bnd ? 0 : m_count + 1;
        m_active = 1;
      end else begin
        m_count  = m_n - 1;
        m_active = 0;
      end
    end
  end

  // High for the first HI half-periods of each period; odd N rises half a clk late
  function automatic bit exp_clk(input bit first_half, input bit rst_ok);
    int hi;
    hi = (m_n + 1) / 2;
    if (!m_active || m_count >= hi) return 1'b0;
    if ((m_n % 2 == 1) && first_half && m_count == 0) return 1'b0;
    if ((m_n % 2 == 1) && !first_half && !rst_ok) return 1'b0;
    return 1'b1;
  endfunction

  task automatic mon(input bit s);
    since_rise++;
    if (s && !prev_s) begin
      last_period = since_rise;
      since_rise  = 0;
      hi_run      = 0;
    end
    if (s) hi_run++;
    if (!s && prev_s) last_high = hi_run;
    prev_s = s;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      chk("div_clk_h1", int'(ctl.o_div_clk), int'(exp_clk(1'b1, 1'b1)));
      mon(ctl.o_div_clk);
      @(negedge clk); #1;
      chk("div_clk_h2", int'(ctl.o_div_clk), int'(exp_clk(1'b0, resetn)));
      chk("count", int'(ctl.o_count), m_count);
      chk("div_cur", int'(ctl.o_div_cur), m_n);
      chk("div_pend", int'(ctl.o_div_pend), int'(m_pend));
      chk("div_upd", int'(ctl.o_div_upd), int'(m_upd));
      chk("div_err", int'(ctl.o_div_err), int'(m_err));
      chk("count_end", int'(ctl.o_count_end), int'(ctl.i_enable && (m_count == m_n - 1)));
      mon(ctl.o_div_clk);
      if (ctl.o_div_upd) upd_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_count(input int v);
    int k;
    k = 0;
    while (int'(ctl.o_count) != v && k < 100) begin tick(1); k++; end
    chk("wait_count", int'(ctl.o_count), v);
  endtask

  task automatic wait_upd();
    int k;
    k = 0;
    while (!ctl.o_div_upd && k < 100) begin tick(1); k++; end
    chk("wait_upd", int'(ctl.o_div_upd), 1);
  endtask

  task automatic load(input int v);
    ctl.i_div = WIDTH'(v); ctl.i_div_load = 1'b1;
    tick(1);
    ctl.i_div_load = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; upd_seen = 0;
    prev_s = 0; since_rise = 0; hi_run = 0; last_high = 0; last_period = 0;
    resetn = 1'b0; ctl.i_enable = 1'b0; ctl.i_div = '0; ctl.i_div_load = 1'b0;
    tick(2);
    chk("rst_count", int'(ctl.o_count), 4);
    chk("rst_div_cur", int'(ctl.o_div_cur), 5);
    chk("rst_div_clk", int'(ctl.o_div_clk), 0);
    chk("rst_pend", int'(ctl.o_div_pend), 0);

    resetn = 1'b1; ctl.i_enable = 1'b1;
    tick(12);
    chk("n5_period", last_period, 10);
    chk("n5_high", last_high, 5);

    load(1);
    chk("err_div1", int'(ctl.o_div_err), 1);
    load(0);
    chk("err_div0", int'(ctl.o_div_err), 1);
    chk("err_pend", int'(ctl.o_div_pend), 0);
    chk("err_div_cur", int'(ctl.o_div_cur), 5);
    tick(10);
    chk("err_period", last_period, 10);

    wait_count(1);
    load(4);
    chk("n4_pend", int'(ctl.o_div_pend), 1);
    chk("n4_old_cur", int'(ctl.o_div_cur), 5);
    wait_upd();
    chk("n4_cur", int'(ctl.o_div_cur), 4);
    tick(12);
    chk("n4_period", last_period, 8);
    chk("n4_high", last_high, 4);

    wait_count(0);
    upd_seen = 0;
    load(6);
    load(3);
    tick(10);
    chk("last_wins_upd", upd_seen, 1);
    chk("last_wins_cur", int'(ctl.o_div_cur), 3);
    chk("n3_period", last_period, 6);
    chk("n3_high", last_high, 3);

    load(8);
    wait_upd();
    tick(10);
    wait_count(1);
    ctl.i_enable = 1'b0;
    tick(1);
    chk("idle_count", int'(ctl.o_count), 7);
    chk("idle_clk", int'(ctl.o_div_clk), 0);
    tick(3);
    ctl.i_enable = 1'b1;
    tick(20);
    chk("n8_period", last_period, 16);
    chk("n8_high", last_high, 8);

    wait_count(2);
    load(10);
    chk("p10_pend", int'(ctl.o_div_pend), 1);
    resetn = 1'b0;
    tick(1);
    chk("mid_rst_count", int'(ctl.o_count), 4);
    chk("mid_rst_cur", int'(ctl.o_div_cur), 5);
    chk("mid_rst_pend", int'(ctl.o_div_pend), 0);
    chk("mid_rst_clk", int'(ctl.o_div_clk), 0);
    resetn = 1'b1;
    upd_seen = 0;
    tick(15);
    chk("post_rst_upd", upd_seen, 0);
    chk("post_rst_cur", int'(ctl.o_div_cur), 5);
    chk("post_rst_period", last_period, 10);
    chk("post_rst_high", last_high, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
